// File: rtl/cla_alu_pipe_if.sv
// Operand/result handshake bus for cla_alu_pipe: valid/ready in, valid/ready out.
interface cla_alu_pipe_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic [3:0]       flags;

   modport master (output in_valid, a, b, op, cin, out_ready,
                   input  in_ready, out_valid, sum, flags);
   modport slave  (input  in_valid, a, b, op, cin, out_ready,
                   output in_ready, out_valid, sum, flags);
endinterface

// File: rtl/cla_alu_pipe.sv
// Two-stage pipelined carry-lookahead add/sub with NZCV flags and valid/ready flow control.
// Stage 1 registers bit and 4-bit group g/p; stage 2 resolves block and group lookahead.
module cla_alu_pipe #(
   parameter int WIDTH = 64
) (
   input  logic          clk,
   input  logic          reset,
   cla_alu_pipe_if.slave bus
);
   localparam int NG = WIDTH / 4;
   localparam int NB = WIDTH / 16;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBC = 2'b11
   } op_e;

   // Carry into each of four positions, flat sum-of-products from ci.
   function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p, input logic ci);
      logic [3:0] c;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   logic             v1, v2, load1, load2;
   logic [WIDTH-1:0] b_cond, g_in, p_in, g_r, p_r;
   logic [NG-1:0]    gg_in, pg_in, gg_r, pg_r;
   logic             c0_in, c0_r;

   assign load2        = !v2 || bus.out_ready;
   assign load1        = !v1 || load2;
   // Reset empties both stages, so the input side reports ready throughout it.
   assign bus.in_ready = load1 || reset;

   assign b_cond = bus.op[0] ? ~bus.b : bus.b;

   always_comb begin
      g_in = bus.a & b_cond;
      p_in = bus.a ^ b_cond;
      // NOTE: the default arm assigns c0_in on every path, so no latch is inferred.
      case (op_e'(bus.op))
         OP_ADD:  c0_in = 1'b0;
         OP_SUB:  c0_in = 1'b1;
         default: c0_in = bus.cin;
      endcase
      for (int q = 0; q < NG; q++) begin
         gg_in[q] = group_gen(g_in[4*q +: 4], p_in[4*q +: 4]);
         pg_in[q] = &p_in[4*q +: 4];
      end
   end

   // NOTE: non-blocking assignments make every register sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0;
      end else if (load1) begin
         v1 <= bus.in_valid;
      end
   end

   // NOTE: datapath registers have no reset; they are only observed behind v1/v2.
   always_ff @(posedge clk) begin
      if (load1 && bus.in_valid) begin
         g_r  <= g_in;
         p_r  <= p_in;
         gg_r <= gg_in;
         pg_r <= pg_in;
         c0_r <= c0_in;
      end
   end

   logic [NB-1:0]    bg, bp;
   logic [NB:0]      blk_c;
   logic [NG-1:0]    grp_c;
   logic [WIDTH-1:0] c, sum_n;
   logic [3:0]       flags_n;
   logic             term;

   always_comb begin
      term = 1'b0;
      for (int j = 0; j < NB; j++) begin
         bg[j] = group_gen(gg_r[4*j +: 4], pg_r[4*j +: 4]);
         bp[j] = &pg_r[4*j +: 4];
      end
      // Block carries as explicit products so no carry ripples block to block.
      for (int j = 0; j <= NB; j++) begin
         blk_c[j] = c0_r;
         for (int m = 0; m < j; m++) blk_c[j] = blk_c[j] & bp[m];
         for (int k = 0; k < j; k++) begin
            term = bg[k];
            for (int m = k + 1; m < j; m++) term = term & bp[m];
            blk_c[j] = blk_c[j] | term;
         end
      end
      for (int j = 0; j < NB; j++) begin
         grp_c[4*j +: 4] = carries4(gg_r[4*j +: 4], pg_r[4*j +: 4], blk_c[j]);
      end
      for (int q = 0; q < NG; q++) begin
         c[4*q +: 4] = carries4(g_r[4*q +: 4], p_r[4*q +: 4], grp_c[q]);
      end
      sum_n   = p_r ^ c;
      flags_n = {sum_n[WIDTH-1], ~|sum_n, blk_c[NB], blk_c[NB] ^ c[WIDTH-1]};
   end

   logic [WIDTH-1:0] sum_r;
   logic [3:0]       flags_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         v2      <= 1'b0;
         sum_r   <= '0;
         flags_r <= 4'b0000;
      end else if (load2) begin
         v2 <= v1;
         if (v1) begin
            sum_r   <= sum_n;
            flags_r <= flags_n;
         end
      end
   end

   assign bus.out_valid = v2;
   assign bus.sum       = sum_r;
   assign bus.flags     = flags_r;
endmodule
